// File: rtl/spi_tx_scheduler_if.sv
// Byte-stream bundle between the requesters, the TX scheduler and the SPI byte serializer.
// The master modport is the scheduler's view; slave is the requester/serializer side.
interface spi_tx_scheduler_if #(
  parameter int N_REQ = 4
);
  logic [N_REQ-1:0]   req_valid;
  logic [8*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]   req_last;
  logic [N_REQ-1:0]   req_ready;
  logic [7:0]         tx_data;
  logic               tx_valid;
  logic               tx_ready;
  logic [3:0]         grant_id;
  logic               frame_active;
  logic               trunc_err;

  modport master (
    input  req_valid, req_data, req_last, tx_ready,
    output req_ready, tx_data, tx_valid, grant_id, frame_active, trunc_err
  );

  modport slave (
    output req_valid, req_data, req_last, tx_ready,
    input  req_ready, tx_data, tx_valid, grant_id, frame_active, trunc_err
  );
endinterface

// File: rtl/spi_tx_scheduler.sv
// Round-robin scheduler sharing one SPI byte serializer among N_REQ byte streams.
// Each grant becomes a frame: header {4'hA, id}, payload up to MAX_LEN bytes, then GAP_CYCLES idle.
module spi_tx_scheduler #(
  parameter int N_REQ      = 4,
  parameter int MAX_LEN    = 16,
  parameter int GAP_CYCLES = 2
) (
  input  logic                clk,
  input  logic                rst,
  spi_tx_scheduler_if.master  bus
);

  localparam int         IDX_W       = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [7:0] LP_LAST_IDX = 8'(MAX_LEN - 1);
  localparam logic [7:0] LP_GAP_END  = 8'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HEADER,
    S_PAYLOAD,
    S_GAP
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [IDX_W-1:0]   r_grant;
  logic [IDX_W-1:0]   r_ptr;
  logic [7:0]         r_cnt;
  logic [7:0]         r_gap;
  logic               r_trunc;

  logic [IDX_W-1:0]   w_sel;
  logic               w_found;
  int                 w_off;
  int                 w_best;
  logic               w_req_valid;
  logic [7:0]         w_req_data;
  logic               w_req_last;
  logic               w_xfer;
  logic               w_trunc_hit;
  logic               w_tx_valid;
  logic [7:0]         w_tx_data;
  logic               w_frame;
  logic [N_REQ-1:0]   w_ready;

  // Pick the valid requester with the smallest distance past the last grant.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    w_sel   = '0;
    w_found = 1'b0;
    w_best  = N_REQ;
    w_off   = 0;
    for (int k = 0; k < N_REQ; k++) begin
      if (bus.req_valid[k]) begin
        w_off = (k + N_REQ - int'(r_ptr) - 1) % N_REQ;
        if (w_off < w_best) begin
          w_best  = w_off;
          w_sel   = IDX_W'(k);
          w_found = 1'b1;
        end
      end
    end
  end

  always_comb begin
    w_req_valid = 1'b0;
    w_req_data  = 8'h00;
    w_req_last  = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      if (IDX_W'(k) == r_grant) begin
        w_req_valid = bus.req_valid[k];
        w_req_data  = bus.req_data[8*k +: 8];
        w_req_last  = bus.req_last[k];
      end
    end
  end

  always_comb begin
    w_next      = r_state;
    w_tx_valid  = 1'b0;
    w_tx_data   = 8'h00;
    w_frame     = 1'b0;
    w_ready     = '0;
    w_xfer      = 1'b0;
    w_trunc_hit = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_found) w_next = S_HEADER;
      end
      S_HEADER: begin
        w_tx_valid = 1'b1;
        w_tx_data  = {4'hA, 4'(r_grant)};
        w_frame    = 1'b1;
        if (bus.tx_ready) w_next = S_PAYLOAD;
      end
      S_PAYLOAD: begin
        w_tx_valid = w_req_valid;
        w_tx_data  = w_req_data;
        w_frame    = 1'b1;
        for (int k = 0; k < N_REQ; k++) begin
          w_ready[k] = (IDX_W'(k) == r_grant) & bus.tx_ready;
        end
        w_xfer = w_req_valid & bus.tx_ready;
        if (w_xfer && (w_req_last || r_cnt == LP_LAST_IDX)) begin
          w_trunc_hit = ~w_req_last;
          w_next      = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
        end
      end
      S_GAP: begin
        if (r_gap == LP_GAP_END) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
    // While reset is held nothing may be offered or consumed, so a requester's byte survives it.
    if (!rst) begin
      w_tx_valid = 1'b0;
      w_tx_data  = 8'h00;
      w_frame    = 1'b0;
      w_ready    = '0;
      w_xfer     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst) begin
      r_state <= S_IDLE;
      r_grant <= '0;
      r_ptr   <= IDX_W'(N_REQ - 1);
      r_cnt   <= 8'h00;
      r_gap   <= 8'h00;
      r_trunc <= 1'b0;
    end else begin
      r_state <= w_next;
      r_trunc <= w_trunc_hit;
      if (r_state == S_IDLE && w_found) begin
        r_grant <= w_sel;
        r_ptr   <= w_sel;
      end
      if (r_state == S_HEADER && bus.tx_ready) begin
        r_cnt <= 8'h00;
      end else if (w_xfer) begin
        r_cnt <= r_cnt + 8'd1;
      end
      r_gap <= (r_state == S_GAP) ? r_gap + 8'd1 : 8'h00;
    end
  end

  assign bus.tx_valid     = w_tx_valid;
  assign bus.tx_data      = w_tx_data;
  assign bus.req_ready    = w_ready;
  assign bus.frame_active = w_frame;
  assign bus.grant_id     = 4'(r_grant);
  assign bus.trunc_err    = r_trunc;

endmodule

// File: doc/spi_tx_scheduler.md
Name: spi_tx_scheduler

Overview:
- Round-robin scheduler that shares the single SPI byte serializer among N_REQ byte-stream requesters (hash table output channels).
- Grants one requester at a time and frames its bytes behind a header byte carrying the requester ID.
- Enforces a maximum frame length and an idle gap between frames, so the serializer's enable line drops between frames.
- Sits between the hash table channel outputs and the serializer's byte input.

Parameters:
- N_REQ, 4: number of requesters; 2..16.
- MAX_LEN, 16: maximum payload bytes per frame; 1..255.
- GAP_CYCLES, 2: idle clk cycles inserted after every frame; 0..255.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-low reset.
- req_valid  input  N_REQ  per-requester byte-valid.
- req_data  input  8*N_REQ  per-requester byte; requester k occupies bits [8k+7:8k].
- req_last  input  N_REQ  marks the final byte of a requester's frame; qualified by req_valid.
- req_ready  output  N_REQ  per-requester byte accept.
- tx_data  output  8  byte to the serializer.
- tx_valid  output  1  byte to the serializer is valid.
- tx_ready  input  1  serializer accepts the byte this cycle.
- grant_id  output  4  currently or most recently granted requester.
- frame_active  output  1  high from HEADER through the end of PAYLOAD.
- trunc_err  output  1  one-cycle pulse when a frame is cut at MAX_LEN.

Behaviour:
- Reset (rst=0 at a clk edge):
  - State goes to IDLE.
  - tx_valid=0, tx_data=0, req_ready=0, grant_id=0, frame_active=0, trunc_err=0.
  - Byte and gap counters clear to 0.
  - RR pointer = N_REQ-1, so requester 0 has first priority.
  - Reset mid-frame abandons the frame with no trailing bytes; the byte the requester was presenting stays unconsumed.
- Handshake: a transfer occurs on any edge with tx_valid & tx_ready.
  - Once asserted, tx_valid/tx_data stay stable until accepted.
- States:
  - IDLE:
    - tx_valid=0.
    - If any req_valid is high, select the first asserted index searching ptr+1, ptr+2, ... modulo N_REQ.
    - Register the selection into grant_id and ptr; next state HEADER.
    - Arbitration decision takes 1 cycle; no header is presented in the IDLE cycle.
  - HEADER:
    - tx_valid=1, tx_data={4'hA, grant_id}, frame_active=1, req_ready=0.
    - On transfer: byte counter cleared to 0; next state PAYLOAD.
  - PAYLOAD:
    - tx_valid=req_valid[g], tx_data=req_data[g], req_ready[g]=tx_ready (combinational); all other req_ready bits are 0.
    - On each transfer, the byte counter increments.
    - If req_last[g]=1 on the transferring byte: next state GAP.
    - Else if the transferring byte is number MAX_LEN (counter==MAX_LEN-1): next state GAP and trunc_err=1 for the following cycle.
    - A truncated requester's remaining bytes form a new frame with a new header, under normal arbitration.
    - req_valid[g] deasserting mid-frame is legal: tx_valid drops and the state holds.
  - GAP:
    - tx_valid=0, frame_active=0.
    - Hold exactly GAP_CYCLES cycles, then go to IDLE.
    - If GAP_CYCLES=0, go directly to IDLE.
- Fairness:
  - The pointer updates only at grant.
  - A requester granted last has the lowest priority in the next arbitration.
  - Requests from non-granted requesters arriving mid-frame wait; they are never dropped.
- Latency: frame-to-frame spacing is ≥ GAP_CYCLES+1 idle tx cycles (gap plus IDLE), plus the header cycle.
- Byte counter width: 8 bits; it never wraps because of the MAX_LEN bound.
- Simultaneous req_last and count==MAX_LEN-1: normal end, trunc_err=0.

Test Plan:
- Reset then single frame: req0 sends 3 bytes (11,22,33, last on 33), tx_ready=1.
  - Required: tx stream A0,11,22,33.
  - tx_valid low for 2 cycles afterwards; then 1 IDLE cycle.
  - trunc_err never asserts.
- All 4 requesters hold 1-byte frames continuously.
  - Required: headers in order A0,A1,A2,A3,A0.
  - Each frame separated by ≥3 idle cycles.
- Backpressure: tx_ready toggles 1/0 during a 4-byte frame from req2.
  - Required: tx_data is held stable while tx_ready=0.
  - req_ready[2] mirrors tx_ready.
  - Bytes arrive in order, with none duplicated or lost.
- Truncation: MAX_LEN=4; req1 streams 6 bytes (last on byte 6).
  - Required: A1 plus 4 bytes, trunc_err pulses once, gap.
  - Then A1 plus 2 bytes (if no other requester is pending), with no trunc_err.
- Reset mid-payload after byte 2 of a 5-byte frame.
  - Required: the next cycle has all outputs at reset values.
  - The subsequent frame starts with header A0 when req0 is requesting.
- Bubble: req3 deasserts req_valid for 3 cycles mid-frame.
  - Required: tx_valid=0 for those cycles, state and grant_id=3 hold, and the frame completes normally.
